nzp_br_ctrl: RTL and testbench

NZP_BR_CTRL -- requirements
Module: nzp_br_ctrl

---
 rtl/lc3_pkg.sv | 37 +++
 rtl/nzp_reg.sv | 36 +++
 rtl/nzp_br_ctrl.sv | 116 +++++++++++
 tb/tb_nzp_br_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// ----------------------------------------------------------------------------
// lc3_pkg
// Shared definitions for the LC-3 branch-control slice:
//   - OP_BR           : opcode of the conditional branch instruction
//   - PCMUX_*         : PC source select encodings
//   - br_state_e      : branch-control FSM states
//   - cc_from_bus()   : condition-code derivation from a bus value
// ----------------------------------------------------------------------------
package lc3_pkg;

  localparam logic [3:0] OP_BR = 4'b0000;

  localparam logic [1:0] PCMUX_PC1  = 2'b00;  // PC + 1
  localparam logic [1:0] PCMUX_BUS  = 2'b01;  // datapath bus
  localparam logic [1:0] PCMUX_ADDR = 2'b10;  // address adder

  localparam logic [2:0] NZP_RESET = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LDBEN = 3'd1,
    S_EVAL  = 3'd2,
    S_TAKE  = 3'd3,
    S_DONE  = 3'd4
  } br_state_e;

  // Condition codes are one-hot {N,Z,P}: negative wins on the sign bit,
  // zero only for an all-zero bus, positive otherwise.
  function automatic logic [2:0] cc_from_bus(input logic [15:0] bus);
    logic [2:0] cc;
    if (bus[15])            cc = 3'b100;
    else if (bus == 16'h0)  cc = 3'b010;
    else                    cc = 3'b001;
    return cc;
  endfunction

endpackage

// File: rtl/nzp_reg.sv
// ----------------------------------------------------------------------------
// nzp_reg
// Condition-code register. Loads one-hot {N,Z,P} from Bus when LD_CC is high.
// Ports:
//   Clk    in   system clock, rising edge
//   Reset  in   synchronous active-low reset (nzp -> 010)
//   LD_CC  in   load enable
//   Bus    in   [15:0] value from which N/Z/P are derived
//   nzp    out  [2:0] registered condition codes
// ----------------------------------------------------------------------------
module nzp_reg
  import lc3_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LD_CC,
  input  logic [15:0] Bus,
  output logic [2:0]  nzp
);

  logic [2:0] nzp_q;
  logic [2:0] nzp_d;

  always_comb begin
    nzp_d = nzp_q;
    if (LD_CC) nzp_d = cc_from_bus(Bus);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) nzp_q <= NZP_RESET;
    else        nzp_q <= nzp_d;
  end

  assign nzp = nzp_q;

endmodule

// File: rtl/nzp_br_ctrl.sv
// ----------------------------------------------------------------------------
// nzp_br_ctrl
// Branch-control sequencer for the LC-3 BR instruction. Owns the condition
// codes, latches the branch mask on dispatch, strobes the external BEN block,
// and on a taken branch loads the PC from the address adder.
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous active-low reset
//   LD_CC      in   load condition codes from Bus
//   Bus        in   [15:0] datapath bus
//   start      in   pulse: IR holds a newly dispatched instruction
//   IR         in   [15:0] instruction register
//   BEN        in   registered branch-enable from the BEN block
//   nzp        out  [2:0] condition codes {N,Z,P}
//   IR_11_9    out  [2:0] latched branch mask
//   LD_BEN     out  BEN load strobe
//   LD_PC      out  PC load strobe (taken branch)
//   PCMUX_sel  out  [1:0] PC source select
//   busy       out  branch in flight
//   done       out  completion pulse
//   taken_cnt  out  [15:0] taken branches since reset (wraps)
// ----------------------------------------------------------------------------
module nzp_br_ctrl
  import lc3_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LD_CC,
  input  logic [15:0] Bus,
  input  logic        start,
  input  logic [15:0] IR,
  input  logic        BEN,
  output logic [2:0]  nzp,
  output logic [2:0]  IR_11_9,
  output logic        LD_BEN,
  output logic        LD_PC,
  output logic [1:0]  PCMUX_sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] taken_cnt
);

  br_state_e   state_q, state_d;
  logic [2:0]  mask_q, mask_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  // Operand bits of IR are not used by the branch sequencer.
  logic unused_ir;
  assign unused_ir = ^IR[8:0];

  nzp_reg u_nzp_reg (
    .Clk   (Clk),
    .Reset (Reset),
    .LD_CC (LD_CC),
    .Bus   (Bus),
    .nzp   (nzp)
  );

  // Outputs are a pure decode of the current state, so every strobe lasts
  // exactly one state and reset forces them all low on the next cycle.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    taken_cnt_d = taken_cnt_q;
    LD_BEN      = 1'b0;
    LD_PC       = 1'b0;
    PCMUX_sel   = PCMUX_PC1;
    done        = 1'b0;
    busy        = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (start && (IR[15:12] == OP_BR)) begin
          mask_d  = IR[11:9];
          state_d = S_LDBEN;
        end
      end
      S_LDBEN: begin
        LD_BEN  = 1'b1;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        state_d = BEN ? S_TAKE : S_DONE;
      end
      S_TAKE: begin
        LD_PC       = 1'b1;
        PCMUX_sel   = PCMUX_ADDR;
        taken_cnt_d = taken_cnt_q + 16'd1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign IR_11_9   = mask_q;
  assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_nzp_br_ctrl.sv
module tb_nzp_br_ctrl;

  logic        Clk;
  logic        Reset;
  logic        LD_CC;
  logic [15:0] Bus;
  logic        start;
  logic [15:0] IR;
  logic        BEN;
  logic [2:0]  nzp;
  logic [2:0]  IR_11_9;
  logic        LD_BEN;
  logic        LD_PC;
  logic [1:0]  PCMUX_sel;
  logic        busy;
  logic        done;
  logic [15:0] taken_cnt;

  nzp_br_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .LD_CC     (LD_CC),
    .Bus       (Bus),
    .start     (start),
    .IR        (IR),
    .BEN       (BEN),
    .nzp       (nzp),
    .IR_11_9   (IR_11_9),
    .LD_BEN    (LD_BEN),
    .LD_PC     (LD_PC),
    .PCMUX_sel (PCMUX_sel),
    .busy      (busy),
    .done      (done),
    .taken_cnt (taken_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Environment model of the BEN block: registers (mask & nzp) on LD_BEN.
  always @(posedge Clk) begin
    if (!Reset)      BEN <= 1'b0;
    else if (LD_BEN) BEN <= |(IR_11_9 & nzp);
  end

  typedef struct {
    int          id;
    logic        taken;
    int          lat;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  logic mon_prev_busy = 1'b0;
  logic mon_seen_pc   = 1'b0;
  int   mon_lat       = 0;

  always @(negedge Clk) begin
    exp_t e;
    if (busy) begin
      if (!mon_prev_busy) begin
        mon_lat     = 1;
        mon_seen_pc = 1'b0;
      end else begin
        mon_lat = mon_lat + 1;
      end
    end
    if (LD_BEN) chk("ldben_cycle", mon_lat, 1);
    if (LD_PC) begin
      mon_seen_pc = 1'b1;
      chk("pcmux_take", {30'd0, PCMUX_sel}, 32'd2);
      if (sb.size() == 0) chk("ld_pc_unexpected", 32'd1, 32'd0);
    end else if (PCMUX_sel != 2'b00) begin
      chk("pcmux_idle", {30'd0, PCMUX_sel}, 32'd0);
    end
    if (done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("br%0d_taken", e.id), {31'd0, mon_seen_pc}, {31'd0, e.taken});
        chk($sformatf("br%0d_latency", e.id), mon_lat, e.lat);
        chk($sformatf("br%0d_taken_cnt", e.id), {16'd0, taken_cnt}, {16'd0, e.cnt});
      end
    end
    mon_prev_busy = busy;
  end

  task automatic push(input int id, input logic taken, input logic [15:0] cnt);
    exp_t e;
    e.id    = id;
    e.taken = taken;
    e.lat   = taken ? 4 : 3;
    e.cnt   = cnt;
    sb.push_back(e);
  endtask

  task automatic load_cc(input logic [15:0] v);
    @(negedge Clk);
    LD_CC = 1'b1;
    Bus   = v;
    @(negedge Clk);
    LD_CC = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] ir);
    @(negedge Clk);
    start = 1'b1;
    IR    = ir;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0 || busy) chk({name, "_timeout"}, 32'd1, 32'd0);
    @(negedge Clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_nzp"},       {29'd0, nzp},       32'h2);
    chk({tag, "_ir_11_9"},   {29'd0, IR_11_9},   32'h0);
    chk({tag, "_taken_cnt"}, {16'd0, taken_cnt}, 32'h0);
    chk({tag, "_strobes"},   {28'd0, LD_BEN, LD_PC, done, busy}, 32'h0);
    chk({tag, "_pcmux"},     {30'd0, PCMUX_sel}, 32'h0);
  endtask

  initial begin
    Reset = 1'b0;
    LD_CC = 1'b0;
    Bus   = '0;
    start = 1'b0;
    IR    = '0;
    repeat (2) @(negedge Clk);
    chk_reset_outs("rst");
    Reset = 1'b1;

    // Condition-code derivation
    load_cc(16'h8000);  chk("cc_8000", {29'd0, nzp}, 32'h4);
    load_cc(16'h0000);  chk("cc_0000", {29'd0, nzp}, 32'h2);
    load_cc(16'h0001);  chk("cc_0001", {29'd0, nzp}, 32'h1);
    load_cc(16'h7FFF);  chk("cc_7fff", {29'd0, nzp}, 32'h1);

    // Taken: nzp=010, mask 010
    load_cc(16'h0000);
    push(1, 1'b1, 16'd1);
    pulse_start(16'h0400);
    drain("br1");

    // Not taken: nzp=001, mask 100
    load_cc(16'h0001);
    push(2, 1'b0, 16'd1);
    pulse_start(16'h0800);
    drain("br2");

    // Non-branch opcode is ignored
    pulse_start(16'h1000);
    repeat (3) begin
      chk("add_busy", {31'd0, busy}, 32'd0);
      @(negedge Clk);
    end
    chk("add_mask_kept", {29'd0, IR_11_9}, 32'h4);

    // Start during EVAL is ignored; mask 001 with nzp=001 taken
    push(3, 1'b1, 16'd2);
    @(negedge Clk); start = 1'b1; IR = 16'h0200;  // IDLE, accepted
    @(negedge Clk); start = 1'b0;                 // LDBEN
    @(negedge Clk); start = 1'b1; IR = 16'h0E00;  // EVAL
    @(negedge Clk); start = 1'b0;
    chk("eval_start_mask", {29'd0, IR_11_9}, 32'h1);
    drain("br3");

    // Mask 000 never taken, mask 111 always taken
    push(4, 1'b0, 16'd2);
    pulse_start(16'h0000);
    drain("br4");
    push(5, 1'b1, 16'd3);
    pulse_start(16'h0E00);
    drain("br5");

    // LD_CC coincident with LD_BEN: BEN sees pre-edge nzp (001)
    push(6, 1'b1, 16'd4);
    @(negedge Clk); start = 1'b1; IR = 16'h0200;
    @(negedge Clk); start = 1'b0; LD_CC = 1'b1; Bus = 16'h8000;
    @(negedge Clk); LD_CC = 1'b0;
    drain("br6");
    chk("cc_in_flight", {29'd0, nzp}, 32'h4);

    // Reset during EVAL aborts a would-be-taken branch
    load_cc(16'h0000);
    @(negedge Clk); start = 1'b1; IR = 16'h0400;
    @(negedge Clk); start = 1'b0;
    @(negedge Clk); Reset = 1'b0; LD_CC = 1'b1; Bus = 16'h8000; start = 1'b1;
    @(negedge Clk); Reset = 1'b1; LD_CC = 1'b0; start = 1'b0;
    chk_reset_outs("abort");
    repeat (4) @(negedge Clk);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    // Counter wrap FFFF -> 0000
    @(negedge Clk);
    force dut.taken_cnt_q = 16'hFFFF;
    @(negedge Clk);
    release dut.taken_cnt_q;
    @(negedge Clk);
    chk("cnt_preload", {16'd0, taken_cnt}, 32'hFFFF);
    push(7, 1'b1, 16'h0000);
    pulse_start(16'h0400);
    drain("br7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
